// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared constants and types for the ID/EX pipeline slice.
//   XLEN            default datapath width
//   CTRL_W          width of the packed control word
//   CTRL_*          bit offsets of each control field inside the control word
//   RESULT_SRC_MEM  ResultSrc encoding that marks a load
//   REG_ZERO        index of the hard-wired zero register
//   next_sel_e      what the ID/EX register loads on the next edge
package pipeline_pkg;

  localparam int XLEN      = 32;
  localparam int CTRL_W    = 10;
  localparam int REG_IDX_W = 5;
  localparam int BUBBLE_W  = 16;

  // Control word layout, MSB to LSB.
  localparam int CTRL_REG_WRITE      = 9;
  localparam int CTRL_RESULT_SRC_MSB = 8;
  localparam int CTRL_RESULT_SRC_LSB = 7;
  localparam int CTRL_MEM_WRITE      = 6;
  localparam int CTRL_JUMP           = 5;
  localparam int CTRL_BRANCH         = 4;
  localparam int CTRL_ALU_CTRL_MSB   = 3;
  localparam int CTRL_ALU_CTRL_LSB   = 1;
  localparam int CTRL_ALU_SRC        = 0;

  localparam logic [1:0]           RESULT_SRC_MEM = 2'b01;
  localparam logic [REG_IDX_W-1:0] REG_ZERO       = 5'd0;
  localparam logic [BUBBLE_W-1:0]  BUBBLE_MAX     = 16'hFFFF;

  typedef enum logic [1:0] {
    NEXT_CAPTURE,
    NEXT_FLUSH,
    NEXT_BUBBLE,
    NEXT_IDLE
  } next_sel_e;

endpackage

// File: rtl/hazard_load_use.sv
// hazard_load_use: combinational load-use detector between the decode slot
// and the instruction currently in execute.
//   valid_e, result_src_e, rd_e  instruction in execute (valid, ResultSrc, dest)
//   valid_d, rs1_d, rs2_d        instruction in decode (valid, sources)
//   pc_src_e                     taken branch/jump in execute
//   load_use                     decode needs a value the execute load has not produced
//   stall_d                      hold fetch/decode; suppressed when execute redirects
module hazard_load_use
  import pipeline_pkg::*;
(
  input  logic                 valid_e,
  input  logic [1:0]           result_src_e,
  input  logic [REG_IDX_W-1:0] rd_e,
  input  logic                 valid_d,
  input  logic [REG_IDX_W-1:0] rs1_d,
  input  logic [REG_IDX_W-1:0] rs2_d,
  input  logic                 pc_src_e,
  output logic                 load_use,
  output logic                 stall_d
);

  assign load_use = valid_e && (result_src_e == RESULT_SRC_MEM) && (rd_e != REG_ZERO) &&
                    valid_d && ((rd_e == rs1_d) || (rd_e == rs2_d));

  // A redirect squashes the decode instruction anyway, so holding it is pointless.
  assign stall_d = load_use && !pc_src_e;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion,
// branch flush, write-through bypass of the writeback port and a saturating
// count of inserted bubbles.
//   clk, rst_n                 clock, asynchronous active-low reset
//   ValidD, CtrlD              decode valid and packed control word
//   RD1D, RD2D                 register-bank read data
//   Rs1D, Rs2D, RdD            register indices
//   ImmExtD, PCD, PCPlus4D     immediate, PC, PC+4
//   RegWriteW, RdW, ResultW    writeback port (same values the bank sees)
//   PCSrcE                     taken branch/jump in execute: squash decode
//   ValidE..PCPlus4E           registered execute-stage copies
//   StallD                     hold fetch/decode this cycle
//   BubbleCount                saturating count of flush/load-use bubbles
module id_ex_stage #(
  parameter int XLEN = pipeline_pkg::XLEN
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ValidD,
  input  logic [pipeline_pkg::CTRL_W-1:0] CtrlD,
  input  logic [XLEN-1:0]                RD1D,
  input  logic [XLEN-1:0]                RD2D,
  input  logic [4:0]                     Rs1D,
  input  logic [4:0]                     Rs2D,
  input  logic [4:0]                     RdD,
  input  logic [XLEN-1:0]                ImmExtD,
  input  logic [XLEN-1:0]                PCD,
  input  logic [XLEN-1:0]                PCPlus4D,
  input  logic                           RegWriteW,
  input  logic [4:0]                     RdW,
  input  logic [XLEN-1:0]                ResultW,
  input  logic                           PCSrcE,
  output logic                           ValidE,
  output logic [pipeline_pkg::CTRL_W-1:0] CtrlE,
  output logic [XLEN-1:0]                RD1E,
  output logic [XLEN-1:0]                RD2E,
  output logic [XLEN-1:0]                ImmExtE,
  output logic [XLEN-1:0]                PCE,
  output logic [XLEN-1:0]                PCPlus4E,
  output logic [4:0]                     Rs1E,
  output logic [4:0]                     Rs2E,
  output logic [4:0]                     RdE,
  output logic                           StallD,
  output logic [15:0]                    BubbleCount
);

  import pipeline_pkg::*;

  logic            load_use;
  next_sel_e       next_sel;
  logic            count_event;
  logic [XLEN-1:0] rd1_fwd;
  logic [XLEN-1:0] rd2_fwd;

  hazard_load_use u_hazard (
    .valid_e      (ValidE),
    .result_src_e (CtrlE[CTRL_RESULT_SRC_MSB:CTRL_RESULT_SRC_LSB]),
    .rd_e         (RdE),
    .valid_d      (ValidD),
    .rs1_d        (Rs1D),
    .rs2_d        (Rs2D),
    .pc_src_e     (PCSrcE),
    .load_use     (load_use),
    .stall_d      (StallD)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps synthesis from inferring a latch.
  always_comb begin
    next_sel = NEXT_CAPTURE;
    if (PCSrcE)       next_sel = NEXT_FLUSH;
    else if (load_use) next_sel = NEXT_BUBBLE;
    else if (!ValidD)  next_sel = NEXT_IDLE;
  end

  // Idle slots are not bubbles; a flush that also hides a load-use counts once.
  assign count_event = (next_sel == NEXT_FLUSH) || (next_sel == NEXT_BUBBLE);

  // The bank is written on the same edge we capture, so its read data is stale
  // for a register being written back this cycle. x0 is never forwarded.
  always_comb begin
    rd1_fwd = RD1D;
    rd2_fwd = RD2D;
    if (RegWriteW && (RdW != REG_ZERO) && (RdW == Rs1D)) rd1_fwd = ResultW;
    if (RegWriteW && (RdW != REG_ZERO) && (RdW == Rs2D)) rd2_fwd = ResultW;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ValidE      <= 1'b0;
      CtrlE       <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      BubbleCount <= '0;
    end else begin
      if (next_sel == NEXT_CAPTURE) begin
        ValidE   <= 1'b1;
        CtrlE    <= CtrlD;
        RD1E     <= rd1_fwd;
        RD2E     <= rd2_fwd;
        ImmExtE  <= ImmExtD;
        PCE      <= PCD;
        PCPlus4E <= PCPlus4D;
        Rs1E     <= Rs1D;
        Rs2E     <= Rs2D;
        RdE      <= RdD;
      end else begin
        // Flush, bubble and idle all load an all-zero NOP.
        ValidE   <= 1'b0;
        CtrlE    <= '0;
        RD1E     <= '0;
        RD2E     <= '0;
        ImmExtE  <= '0;
        PCE      <= '0;
        PCPlus4E <= '0;
        Rs1E     <= '0;
        Rs2E     <= '0;
        RdE      <= '0;
      end
      if (count_event && (BubbleCount != BUBBLE_MAX)) BubbleCount <= BubbleCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ValidD;
  logic [9:0]      CtrlD;
  logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0]      Rs1D, Rs2D, RdD;
  logic            RegWriteW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] ResultW;
  logic            PCSrcE;
  logic            ValidE;
  logic [9:0]      CtrlE;
  logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]      Rs1E, Rs2E, RdE;
  logic            StallD;
  logic [15:0]     BubbleCount;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_bubbles = 16'd0;

  localparam logic [9:0] CTRL_ALU  = 10'h201; // RegWrite, ALUSrc, ResultSrc=00
  localparam logic [9:0] CTRL_LOAD = 10'h281; // RegWrite, ResultSrc=01, ALUSrc
  localparam logic [9:0] CTRL_MIX  = 10'h3A5; // ResultSrc=11, not a load

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .ValidD(ValidD), .CtrlD(CtrlD), .RD1D(RD1D), .RD2D(RD2D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .PCSrcE(PCSrcE),
    .ValidE(ValidE), .CtrlE(CtrlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .StallD(StallD),
    .BubbleCount(BubbleCount)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic v, input logic [9:0] ctrl, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2,
                         input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc);
    ValidD = v; CtrlD = ctrl; Rs1D = rs1; Rs2D = rs2; RdD = rd;
    RD1D = r1; RD2D = r2; ImmExtD = imm; PCD = pc; PCPlus4D = pc + 32'd4;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; PCSrcE = 1'b0; RegWriteW = 1'b0; RdW = 5'd0; ResultW = '0;
    drive_d(1'b1, CTRL_LOAD, 5'd1, 5'd2, 5'd3, 32'hAAAA0001, 32'hBBBB0002, 32'h10, 32'h100);
    repeat (2) step();
    checks++; if (ValidE !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ValidE); end
    checks++; if (CtrlE !== 10'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 000", CtrlE); end
    checks++; if ({RD1E, RD2E, ImmExtE, PCE, PCPlus4E} !== '0) begin errors++; $display("FAIL reset_data: got nonzero, expected 0"); end
    checks++; if ({Rs1E, Rs2E, RdE} !== 15'h0) begin errors++; $display("FAIL reset_idx: got %h expected 0", {Rs1E, Rs2E, RdE}); end
    checks++; if (BubbleCount !== 16'h0) begin errors++; $display("FAIL reset_count: got %h expected 0000", BubbleCount); end
    checks++; if (StallD !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", StallD); end
    @(negedge clk); rst_n = 1'b1;
    step(); // first edge after release captures
    checks++; if (ValidE !== 1'b1 || RdE !== 5'd3) begin errors++; $display("FAIL first_capture: got valid=%b rd=%0d expected valid=1 rd=3", ValidE, RdE); end
    // Drop the load before it can cause any hazard further on.
    drive_d(1'b0, '0, '0, '0, '0, '0, '0, '0, '0);
    step();
  endtask

  task automatic test_capture();
    drive_d(1'b1, CTRL_MIX, 5'd9, 5'd10, 5'd11, 32'h12345678, 32'h9ABCDEF0, 32'hFFFFF800, 32'h0000_2000);
    step();
    checks++; if (ValidE !== 1'b1) begin errors++; $display("FAIL cap_valid: got %b expected 1", ValidE); end
    checks++; if (CtrlE !== CTRL_MIX) begin errors++; $display("FAIL cap_ctrl: got %h expected %h", CtrlE, CTRL_MIX); end
    checks++; if (RD1E !== 32'h12345678 || RD2E !== 32'h9ABCDEF0) begin errors++; $display("FAIL cap_rd: got %h/%h expected 12345678/9abcdef0", RD1E, RD2E); end
    checks++; if (ImmExtE !== 32'hFFFFF800 || PCE !== 32'h2000 || PCPlus4E !== 32'h2004) begin errors++; $display("FAIL cap_imm_pc: got %h/%h/%h expected fffff800/00002000/00002004", ImmExtE, PCE, PCPlus4E); end
    checks++; if (Rs1E !== 5'd9 || Rs2E !== 5'd10 || RdE !== 5'd11) begin errors++; $display("FAIL cap_idx: got %0d/%0d/%0d expected 9/10/11", Rs1E, Rs2E, RdE); end
    checks++; if (BubbleCount !== exp_bubbles) begin errors++; $display("FAIL cap_count: got %0d expected %0d", BubbleCount, exp_bubbles); end
  endtask

  task automatic test_bypass();
    RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'hDEADBEEF;
    drive_d(1'b1, CTRL_ALU, 5'd3, 5'd4, 5'd8, 32'h11111111, 32'h22222222, '0, 32'h40);
    step();
    checks++; if (RD1E !== 32'hDEADBEEF || RD2E !== 32'h22222222) begin errors++; $display("FAIL bypass_rs1: got %h/%h expected deadbeef/22222222", RD1E, RD2E); end
    drive_d(1'b1, CTRL_ALU, 5'd6, 5'd3, 5'd8, 32'h11111111, 32'h22222222, '0, 32'h44);
    step();
    checks++; if (RD1E !== 32'h11111111 || RD2E !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rs2: got %h/%h expected 11111111/deadbeef", RD1E, RD2E); end
    RdW = 5'd0;
    drive_d(1'b1, CTRL_ALU, 5'd0, 5'd0, 5'd8, 32'h11111111, 32'h22222222, '0, 32'h48);
    step();
    checks++; if (RD1E !== 32'h11111111 || RD2E !== 32'h22222222) begin errors++; $display("FAIL bypass_x0: got %h/%h expected 11111111/22222222", RD1E, RD2E); end
    RegWriteW = 1'b0; RdW = 5'd3;
    drive_d(1'b1, CTRL_ALU, 5'd3, 5'd3, 5'd8, 32'h11111111, 32'h22222222, '0, 32'h4C);
    step();
    checks++; if (RD1E !== 32'h11111111 || RD2E !== 32'h22222222) begin errors++; $display("FAIL bypass_nowrite: got %h/%h expected 11111111/22222222", RD1E, RD2E); end
    RdW = 5'd0;
  endtask

  task automatic test_load_use();
    drive_d(1'b1, CTRL_LOAD, 5'd1, 5'd2, 5'd5, 32'h1, 32'h2, 32'h4, 32'h80);
    step();
    drive_d(1'b1, CTRL_ALU, 5'd7, 5'd5, 5'd12, 32'h77, 32'h55, 32'h0, 32'h84);
    #1;
    checks++; if (StallD !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", StallD); end
    step();
    exp_bubbles = exp_bubbles + 16'd1;
    checks++; if (ValidE !== 1'b0 || CtrlE !== 10'h0 || RdE !== 5'd0 || RD2E !== '0) begin errors++; $display("FAIL lu_bubble: got valid=%b ctrl=%h rd=%0d expected 0/000/0", ValidE, CtrlE, RdE); end
    checks++; if (BubbleCount !== exp_bubbles) begin errors++; $display("FAIL lu_count: got %0d expected %0d", BubbleCount, exp_bubbles); end
    checks++; if (StallD !== 1'b0) begin errors++; $display("FAIL lu_release: got %b expected 0", StallD); end
    step();
    checks++; if (ValidE !== 1'b1 || RdE !== 5'd12 || Rs2E !== 5'd5 || PCE !== 32'h84) begin errors++; $display("FAIL lu_capture: got valid=%b rd=%0d rs2=%0d pc=%h expected 1/12/5/84", ValidE, RdE, Rs2E, PCE); end
    // A load to x0 never stalls.
    drive_d(1'b1, CTRL_LOAD, 5'd1, 5'd2, 5'd0, '0, '0, '0, 32'h88);
    step();
    drive_d(1'b1, CTRL_ALU, 5'd0, 5'd0, 5'd13, '0, '0, '0, 32'h8C);
    #1;
    checks++; if (StallD !== 1'b0) begin errors++; $display("FAIL lu_x0: got %b expected 0", StallD); end
    // A non-load writing the source register does not stall either.
    step();
    drive_d(1'b1, CTRL_ALU, 5'd13, 5'd1, 5'd14, '0, '0, '0, 32'h90);
    #1;
    checks++; if (StallD !== 1'b0) begin errors++; $display("FAIL lu_nonload: got %b expected 0", StallD); end
    step();
    checks++; if (BubbleCount !== exp_bubbles) begin errors++; $display("FAIL lu_nostall_count: got %0d expected %0d", BubbleCount, exp_bubbles); end
  endtask

  task automatic test_flush();
    drive_d(1'b1, CTRL_ALU, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, '0, 32'hA0);
    PCSrcE = 1'b1;
    #1;
    checks++; if (StallD !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", StallD); end
    step();
    exp_bubbles = exp_bubbles + 16'd1;
    PCSrcE = 1'b0;
    checks++; if (ValidE !== 1'b0 || CtrlE !== 10'h0 || PCE !== '0) begin errors++; $display("FAIL flush_nop: got valid=%b ctrl=%h pc=%h expected 0/000/0", ValidE, CtrlE, PCE); end
    checks++; if (BubbleCount !== exp_bubbles) begin errors++; $display("FAIL flush_count: got %0d expected %0d", BubbleCount, exp_bubbles); end
    // Flush together with a load-use: one flush, no stall, count +1.
    drive_d(1'b1, CTRL_LOAD, 5'd1, 5'd2, 5'd5, '0, '0, '0, 32'hB0);
    step();
    drive_d(1'b1, CTRL_ALU, 5'd5, 5'd9, 5'd10, '0, '0, '0, 32'hB4);
    PCSrcE = 1'b1;
    #1;
    checks++; if (StallD !== 1'b0) begin errors++; $display("FAIL flush_lu_stall: got %b expected 0", StallD); end
    step();
    exp_bubbles = exp_bubbles + 16'd1;
    PCSrcE = 1'b0;
    checks++; if (ValidE !== 1'b0 || BubbleCount !== exp_bubbles) begin errors++; $display("FAIL flush_lu: got valid=%b count=%0d expected 0/%0d", ValidE, BubbleCount, exp_bubbles); end
  endtask

  task automatic test_back_to_back();
    drive_d(1'b1, CTRL_LOAD, 5'd1, 5'd2, 5'd6, '0, '0, '0, 32'hC0);
    step();
    drive_d(1'b1, CTRL_LOAD, 5'd6, 5'd0, 5'd7, '0, '0, '0, 32'hC4);
    #1;
    checks++; if (StallD !== 1'b1) begin errors++; $display("FAIL b2b_stall1: got %b expected 1", StallD); end
    step();
    step();
    exp_bubbles = exp_bubbles + 16'd1;
    checks++; if (ValidE !== 1'b1 || RdE !== 5'd7) begin errors++; $display("FAIL b2b_cap1: got valid=%b rd=%0d expected 1/7", ValidE, RdE); end
    drive_d(1'b1, CTRL_ALU, 5'd7, 5'd0, 5'd8, '0, '0, '0, 32'hC8);
    #1;
    checks++; if (StallD !== 1'b1) begin errors++; $display("FAIL b2b_stall2: got %b expected 1", StallD); end
    step();
    exp_bubbles = exp_bubbles + 16'd1;
    checks++; if (ValidE !== 1'b0) begin errors++; $display("FAIL b2b_bubble2: got %b expected 0", ValidE); end
    step();
    checks++; if (ValidE !== 1'b1 || RdE !== 5'd8 || BubbleCount !== exp_bubbles) begin errors++; $display("FAIL b2b_cap2: got valid=%b rd=%0d count=%0d expected 1/8/%0d", ValidE, RdE, BubbleCount, exp_bubbles); end
  endtask

  task automatic test_idle();
    drive_d(1'b0, CTRL_ALU, 5'd8, 5'd8, 5'd9, 32'h1, 32'h2, 32'h3, 32'hD0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (ValidE !== 1'b0 || StallD !== 1'b0 || BubbleCount !== exp_bubbles) begin errors++; $display("FAIL idle_%0d: got valid=%b stall=%b count=%0d expected 0/0/%0d", i, ValidE, StallD, BubbleCount, exp_bubbles); end
    end
  endtask

  task automatic test_reset_mid();
    drive_d(1'b1, CTRL_ALU, 5'd1, 5'd2, 5'd3, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h7, 32'hE0);
    step();
    checks++; if (ValidE !== 1'b1 || BubbleCount !== 16'd5) begin errors++; $display("FAIL mid_pre: got valid=%b count=%0d expected 1/5", ValidE, BubbleCount); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ValidE !== 1'b0 || CtrlE !== 10'h0 || BubbleCount !== 16'h0) begin errors++; $display("FAIL mid_async: got valid=%b ctrl=%h count=%0d expected 0/000/0", ValidE, CtrlE, BubbleCount); end
    checks++; if ({RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE} !== '0) begin errors++; $display("FAIL mid_data: got nonzero, expected 0"); end
    @(negedge clk); rst_n = 1'b1;
    exp_bubbles = 16'd0;
    step();
    checks++; if (ValidE !== 1'b1 || RD1E !== 32'hF0F0F0F0) begin errors++; $display("FAIL mid_recapture: got valid=%b rd1=%h expected 1/f0f0f0f0", ValidE, RD1E); end
  endtask

  task automatic test_saturate();
    drive_d(1'b1, CTRL_ALU, 5'd1, 5'd2, 5'd3, '0, '0, '0, 32'hF0);
    PCSrcE = 1'b1;
    repeat (65534) step();
    checks++; if (BubbleCount !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe: got %h expected fffe", BubbleCount); end
    step();
    checks++; if (BubbleCount !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff: got %h expected ffff", BubbleCount); end
    repeat (5) step();
    checks++; if (BubbleCount !== 16'hFFFF || ValidE !== 1'b0) begin errors++; $display("FAIL sat_hold: got count=%h valid=%b expected ffff/0", BubbleCount, ValidE); end
    PCSrcE = 1'b0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_bypass();
    test_load_use();
    test_flush();
    test_back_to_back();
    test_idle();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
